knight_sprite_addr_gen: RTL and testbench
=========================================

# knight_sprite_addr_gen

Address generator and animation sequencer feeding the knight sprite ROM in the VGA pixel path. Takes the current pixel coordinate from the VGA controller, decides whether it falls inside the knight's on-screen bounding box, and produces the ROM address for the current animation frame, with optional horizontal mirroring. Sits between the VGA controller / game logic and the sprite ROM + palette stage, replacing the full-screen stretch addressing used for bring-up.

## Interface
- SPR_W, 50: sprite width in pixels
- SPR_H, 64: sprite height in pixels
- NUM_FRAMES, 4: attack animation frames stored back-to-back in ROM
- HOLD_FRAMES, 6: video frames each animation frame is displayed
- ADDR_W, 14: ROM address width, must satisfy NUM_FRAMES*SPR_W*SPR_H <= 2**ADDR_W

Ports:
- vga_clk  in  1  pixel clock, all logic on posedge
- reset_n  in  1  asynchronous, active-low reset
- DrawX  in  10  current pixel column, 0..639
- DrawY  in  10  current pixel row, 0..479
- frame_start  in  1  one-cycle pulse at start of vertical blank
- knight_x  in  10  sprite top-left column, live from game logic
- knight_y  in  10  sprite top-left row
- facing_left  in  1  1 = mirror sprite horizontally
- attack_req  in  1  request an attack animation, level or pulse
- rom_address  out  ADDR_W  address to sprite ROM
- sprite_on  out  1  1 = rom_address valid, pixel inside sprite box
- attack_busy  out  1  1 while in ATTACK
- attack_done  out  1  one-cycle pulse on ATTACK -> IDLE
- frame_idx  out  2  current animation frame, clog2(NUM_FRAMES) bits

## Operation
- Position latch: knight_x, knight_y, facing_left sampled into shadow registers only on frame_start; all addressing uses shadow values, so no tearing mid-frame.
- Hit test: col_off = DrawX - kx, row_off = DrawY - ky, computed at 11 bits. In box when DrawX >= kx, DrawX < kx+SPR_W, DrawY >= ky, DrawY < ky+SPR_H; sums at 11 bits so a box near x=639 or y=479 never wraps.
- Column: col = facing ? SPR_W-1-col_off : col_off.
- Address: frame_idx*SPR_W*SPR_H + row_off*SPR_W + col. Multiplies by constants only, shift-add acceptable.
- Outside box: rom_address = 0, sprite_on = 0.
- FSM states IDLE, ATTACK:
  - IDLE: frame_idx = 0. attack_req high in any cycle sets pending. On frame_start with pending (or attack_req in same cycle): -> ATTACK, frame_idx = 0, hold_cnt = 0, pending cleared.
  - ATTACK: each frame_start increments hold_cnt; at hold_cnt == HOLD_FRAMES-1, hold_cnt = 0 and frame_idx increments; if frame_idx was NUM_FRAMES-1, instead -> IDLE, frame_idx = 0, attack_done pulses. attack_req ignored, pending not set.
- Reset mid-attack: immediate return to IDLE, animation abandoned, no attack_done.

## Timing
- rom_address and sprite_on registered: valid one posedge after the DrawX/DrawY they correspond to. ROM reads on negedge of that cycle; palette output is registered at the following posedge alongside a one-stage copy of sprite_on.
- Shadow registers, FSM, frame_idx update on the posedge where frame_start = 1; new values affect the pixel sampled that same cycle.
- Full attack lasts NUM_FRAMES*HOLD_FRAMES frame_start pulses: 24 by default.
- Reset values: rom_address 0, sprite_on 0, attack_busy 0, attack_done 0, frame_idx 0, shadow position 0, facing 0, pending 0, state IDLE.

## Structure
- Shared package knight_sprite_pkg: SPR_W, SPR_H, NUM_FRAMES, HOLD_FRAMES defaults, FRAME_SIZE = SPR_W*SPR_H, state enum {IDLE, ATTACK}.
- One sub-module: knight_anim_fsm, holding pending, hold_cnt, frame_idx, attack_busy, attack_done. The top holds shadow registers and address datapath.

## Test plan
- Reset, knight at (100,200), facing 0: DrawX=100, DrawY=200 -> next cycle rom_address 0, sprite_on 1. DrawX=149, DrawY=263 -> 3199. DrawX=150 -> sprite_on 0, address 0.
- facing_left=1 latched on frame_start: DrawX=100, DrawY=200 -> rom_address 49; DrawX=149 -> 0.
- Edge: knight at (620,450), DrawX=639, DrawY=479 -> sprite_on 1, address 29*50+19 = 1469. DrawX=5 -> sprite_on 0, no wrap.
- attack_req pulse mid-frame: attack_busy rises on next frame_start; frame_idx 0,1,2,3 each held 6 frames; attack_done on 24th frame_start. At frame_idx=2, pixel (0,0) of sprite -> address 6400.
- attack_req during ATTACK: no restart, no extra attack after attack_done. attack_req together with frame_start in IDLE: ATTACK entered that cycle.
- knight_x changed mid-frame: addressing unchanged until next frame_start. reset_n low mid-attack: state IDLE, frame_idx 0, no attack_done.

Source files
------------

// File: rtl/knight_sprite_addr_gen_pkg.sv
// Shared constants, animation state type and ROM address helper for the knight sprite path.
package knight_sprite_pkg;

  localparam int SPR_W       = 50;
  localparam int SPR_H       = 64;
  localparam int NUM_FRAMES  = 4;
  localparam int HOLD_FRAMES = 6;
  localparam int ADDR_W      = 14;
  localparam int FRAME_SIZE  = SPR_W * SPR_H;
  localparam int FIDX_W      = $clog2(NUM_FRAMES);
  localparam int HOLD_W      = $clog2(HOLD_FRAMES);

  typedef enum logic {
    IDLE   = 1'b0,
    ATTACK = 1'b1
  } anim_state_e;

  // Constant multipliers only, so synthesis reduces these to shift-add trees.
  function automatic logic [ADDR_W-1:0] sprite_addr(
    input logic [FIDX_W-1:0] fidx,
    input logic [10:0]       row,
    input logic [10:0]       col
  );
    return ADDR_W'(fidx) * ADDR_W'(FRAME_SIZE)
         + ADDR_W'(row)  * ADDR_W'(SPR_W)
         + ADDR_W'(col);
  endfunction

endpackage

// File: rtl/knight_sprite_addr_gen_if.sv
// Pixel/position/animation bundle between VGA controller + game logic and the sprite address generator.
interface knight_sprite_addr_gen_if;
  import knight_sprite_pkg::*;

  logic [9:0]        DrawX;
  logic [9:0]        DrawY;
  logic              frame_start;
  logic [9:0]        knight_x;
  logic [9:0]        knight_y;
  logic              facing_left;
  logic              attack_req;
  logic [ADDR_W-1:0] rom_address;
  logic              sprite_on;
  logic              attack_busy;
  logic              attack_done;
  logic [FIDX_W-1:0] frame_idx;

  modport master (
    output DrawX, DrawY, frame_start, knight_x, knight_y, facing_left, attack_req,
    input  rom_address, sprite_on, attack_busy, attack_done, frame_idx
  );

  modport slave (
    input  DrawX, DrawY, frame_start, knight_x, knight_y, facing_left, attack_req,
    output rom_address, sprite_on, attack_busy, attack_done, frame_idx
  );

endinterface

// File: rtl/knight_sprite_addr_gen_anim_fsm.sv
// Attack animation sequencer: frame index advances every HOLD_FRAMES video frames.
// state  | meaning
// IDLE   | standing pose, frame_idx 0, attack_req latched into pending
// ATTACK | playing frames 0..NUM_FRAMES-1, attack_req ignored
module knight_anim_fsm
  import knight_sprite_pkg::*;
(
  input  logic              vga_clk,
  input  logic              reset_n,
  input  logic              frame_start,
  input  logic              attack_req,
  output logic              attack_busy,
  output logic              attack_done,
  output logic [FIDX_W-1:0] frame_idx,
  output logic [FIDX_W-1:0] frame_idx_nxt
);

  anim_state_e       r_state, w_state_nxt;
  logic              r_pending, w_pending_nxt;
  logic [HOLD_W-1:0] r_hold, w_hold_nxt;
  logic [FIDX_W-1:0] r_fidx, w_fidx_nxt;
  logic              r_done, w_done_nxt;

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_pending <= 1'b0;
      r_hold    <= '0;
      r_fidx    <= '0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pending <= w_pending_nxt;
      r_hold    <= w_hold_nxt;
      r_fidx    <= w_fidx_nxt;
      r_done    <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_pending_nxt = r_pending;
    w_hold_nxt    = r_hold;
    w_fidx_nxt    = r_fidx;
    w_done_nxt    = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_fidx_nxt    = '0;
        w_pending_nxt = r_pending | attack_req;
        if (frame_start && (r_pending || attack_req)) begin
          w_state_nxt   = ATTACK;
          w_hold_nxt    = '0;
          w_pending_nxt = 1'b0;
        end
      end
      ATTACK: begin
        if (frame_start) begin
          if (r_hold == HOLD_W'(HOLD_FRAMES - 1)) begin
            w_hold_nxt = '0;
            if (r_fidx == FIDX_W'(NUM_FRAMES - 1)) begin
              w_state_nxt = IDLE;
              w_fidx_nxt  = '0;
              w_done_nxt  = 1'b1;
            end else begin
              w_fidx_nxt = r_fidx + 1'b1;
            end
          end else begin
            w_hold_nxt = r_hold + 1'b1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign attack_busy   = (r_state == ATTACK);
  assign attack_done   = r_done;
  assign frame_idx     = r_fidx;
  // Look-ahead lets the datapath use the new frame on the frame_start cycle itself.
  assign frame_idx_nxt = w_fidx_nxt;

endmodule

// File: rtl/knight_sprite_addr_gen.sv
// Knight sprite ROM addressing: per-frame position shadow, bounding-box hit test, mirroring and frame offset.
module knight_sprite_addr_gen
  import knight_sprite_pkg::*;
(
  input  logic                     vga_clk,
  input  logic                     reset_n,
  knight_sprite_addr_gen_if.slave  bus
);

  logic [9:0]        r_kx, r_ky;
  logic              r_facing;
  logic [ADDR_W-1:0] r_rom_address;
  logic              r_sprite_on;

  logic [9:0]        w_kx, w_ky;
  logic              w_facing;
  logic [10:0]       w_dx, w_dy, w_kx11, w_ky11;
  logic [10:0]       w_col_off, w_row_off, w_col;
  logic              w_hit;
  logic [FIDX_W-1:0] w_fidx_nxt;
  logic [FIDX_W-1:0] w_fidx;
  logic              w_busy, w_done;

  knight_anim_fsm u_anim (
    .vga_clk       (vga_clk),
    .reset_n       (reset_n),
    .frame_start   (bus.frame_start),
    .attack_req    (bus.attack_req),
    .attack_busy   (w_busy),
    .attack_done   (w_done),
    .frame_idx     (w_fidx),
    .frame_idx_nxt (w_fidx_nxt)
  );

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_kx     <= '0;
      r_ky     <= '0;
      r_facing <= 1'b0;
    end else if (bus.frame_start) begin
      r_kx     <= bus.knight_x;
      r_ky     <= bus.knight_y;
      r_facing <= bus.facing_left;
    end
  end

  // On the frame_start cycle the freshly sampled position already applies.
  assign w_kx     = bus.frame_start ? bus.knight_x    : r_kx;
  assign w_ky     = bus.frame_start ? bus.knight_y    : r_ky;
  assign w_facing = bus.frame_start ? bus.facing_left : r_facing;

  // 11-bit compares keep a box hanging off the right/bottom edge from wrapping.
  assign w_dx      = {1'b0, bus.DrawX};
  assign w_dy      = {1'b0, bus.DrawY};
  assign w_kx11    = {1'b0, w_kx};
  assign w_ky11    = {1'b0, w_ky};
  assign w_col_off = w_dx - w_kx11;
  assign w_row_off = w_dy - w_ky11;
  assign w_hit     = (w_dx >= w_kx11) && (w_dx < w_kx11 + 11'(SPR_W))
                  && (w_dy >= w_ky11) && (w_dy < w_ky11 + 11'(SPR_H));
  assign w_col     = w_facing ? (11'(SPR_W - 1) - w_col_off) : w_col_off;

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rom_address <= '0;
      r_sprite_on   <= 1'b0;
    end else begin
      r_sprite_on   <= w_hit;
      r_rom_address <= w_hit ? sprite_addr(w_fidx_nxt, w_row_off, w_col) : '0;
    end
  end

  assign bus.rom_address = r_rom_address;
  assign bus.sprite_on   = r_sprite_on;
  assign bus.attack_busy = w_busy;
  assign bus.attack_done = w_done;
  assign bus.frame_idx   = w_fidx;

endmodule

// File: tb/tb_knight_sprite_addr_gen.sv
// Directed bench for knight_sprite_addr_gen: hit test, mirroring, edge boxes and the attack sequence.
module tb_knight_sprite_addr_gen;
  import knight_sprite_pkg::*;

  logic vga_clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_cmp   = 0;
  int   n_fail  = 0;

  knight_sprite_addr_gen_if bus ();

  knight_sprite_addr_gen dut (
    .vga_clk (vga_clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 vga_clk = ~vga_clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic pix(input int x, input int y);
    bus.DrawX = 10'(x);
    bus.DrawY = 10'(y);
    step();
  endtask

  task automatic pulse_fs();
    bus.frame_start = 1'b1;
    step();
    bus.frame_start = 1'b0;
  endtask

  task automatic place(input int x, input int y, input logic f);
    bus.knight_x    = 10'(x);
    bus.knight_y    = 10'(y);
    bus.facing_left = f;
    pulse_fs();
  endtask

  initial begin
    bus.DrawX = '0; bus.DrawY = '0; bus.frame_start = 1'b0;
    bus.knight_x = '0; bus.knight_y = '0; bus.facing_left = 1'b0; bus.attack_req = 1'b0;
    #12;
    chk("rst_addr", int'(bus.rom_address), 0);
    chk("rst_on",   int'(bus.sprite_on), 0);
    chk("rst_busy", int'(bus.attack_busy), 0);
    chk("rst_done", int'(bus.attack_done), 0);
    chk("rst_fidx", int'(bus.frame_idx), 0);
    reset_n = 1'b1;
    step();

    // Facing right at (100,200)
    place(100, 200, 1'b0);
    pix(100, 200); chk("tl_on", int'(bus.sprite_on), 1); chk("tl_addr", int'(bus.rom_address), 0);
    pix(149, 263); chk("br_on", int'(bus.sprite_on), 1); chk("br_addr", int'(bus.rom_address), 3199);
    pix(150, 263); chk("right_out_on", int'(bus.sprite_on), 0); chk("right_out_addr", int'(bus.rom_address), 0);
    pix(99, 200);  chk("left_out_on", int'(bus.sprite_on), 0);
    pix(100, 264); chk("below_out_on", int'(bus.sprite_on), 0);

    // Mirrored
    place(100, 200, 1'b1);
    pix(100, 200); chk("mir_tl", int'(bus.rom_address), 49);
    pix(149, 200); chk("mir_tr", int'(bus.rom_address), 0);
    pix(110, 201); chk("mir_mid", int'(bus.rom_address), 50 + 39);

    // Box near bottom-right corner must not wrap onto small coordinates
    place(620, 450, 1'b0);
    pix(639, 479); chk("edge_on", int'(bus.sprite_on), 1); chk("edge_addr", int'(bus.rom_address), 1469);
    pix(5, 479);   chk("nowrap_on", int'(bus.sprite_on), 0); chk("nowrap_addr", int'(bus.rom_address), 0);
    pix(639, 5);   chk("nowrap_y_on", int'(bus.sprite_on), 0);

    // Attack animation
    place(100, 200, 1'b0);
    bus.DrawX = 10'd100; bus.DrawY = 10'd200;
    bus.attack_req = 1'b1; step(); bus.attack_req = 1'b0;
    step();
    chk("pend_busy", int'(bus.attack_busy), 0);
    pulse_fs();
    chk("atk_start_busy", int'(bus.attack_busy), 1);
    chk("atk_start_fidx", int'(bus.frame_idx), 0);
    for (int k = 1; k <= 23; k++) begin
      if (k == 5) bus.attack_req = 1'b1;
      pulse_fs();
      if (k == 7) bus.attack_req = 1'b0;
      chk("atk_busy", int'(bus.attack_busy), 1);
      chk("atk_done_low", int'(bus.attack_done), 0);
      chk("atk_fidx", int'(bus.frame_idx), k / 6);
      chk("atk_addr", int'(bus.rom_address), (k / 6) * 3200);
      step();
    end
    pulse_fs();
    chk("end_done", int'(bus.attack_done), 1);
    chk("end_busy", int'(bus.attack_busy), 0);
    chk("end_fidx", int'(bus.frame_idx), 0);
    chk("end_addr", int'(bus.rom_address), 0);
    step();
    chk("done_one_cycle", int'(bus.attack_done), 0);
    pulse_fs();
    chk("no_extra_attack", int'(bus.attack_busy), 0);

    // Request coincident with frame_start enters ATTACK on that edge
    bus.attack_req = 1'b1;
    pulse_fs();
    bus.attack_req = 1'b0;
    chk("same_cycle_busy", int'(bus.attack_busy), 1);

    // Live knight_x change mid-frame has no effect until frame_start
    bus.knight_x = 10'd300;
    pix(100, 200); chk("shadow_hold_on", int'(bus.sprite_on), 1);
    pix(300, 200); chk("shadow_new_off", int'(bus.sprite_on), 0);
    pulse_fs();
    pix(300, 200); chk("shadow_new_on", int'(bus.sprite_on), 1);

    // Async reset mid-attack
    for (int k = 0; k < 7; k++) pulse_fs();
    chk("pre_rst_fidx", int'(bus.frame_idx), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", int'(bus.attack_busy), 0);
    chk("mid_rst_fidx", int'(bus.frame_idx), 0);
    chk("mid_rst_done", int'(bus.attack_done), 0);
    chk("mid_rst_on",   int'(bus.sprite_on), 0);
    step();
    reset_n = 1'b1;
    for (int k = 0; k < 30; k++) begin
      pulse_fs();
      chk("post_rst_done", int'(bus.attack_done), 0);
      chk("post_rst_busy", int'(bus.attack_busy), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach summary");
    $fatal(1, "timeout");
  end

endmodule
